// File: rtl/uart2vga_pkg.sv
// Shared types and constants for the UART-to-framebuffer loader.
package uart2vga_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR0,
        S_ADDR1,
        S_ADDR2,
        S_LEN,
        S_DATA,
        S_EXPAND,
        S_CCOL,
        S_CLEAR,
        S_RESP
    } loader_state_t;

    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_PIXELS   = 8'h02;
    localparam logic [7:0] CMD_CLEAR    = 8'h03;
    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] ACK          = 8'h06;
    localparam logic [7:0] NAK          = 8'h15;

    localparam int WIDTH_DEF  = 640;
    localparam int HEIGHT_DEF = 480;

    function automatic int max_addr(input int w, input int h);
        return w * h;
    endfunction

    localparam int MAX_ADDR = WIDTH_DEF * HEIGHT_DEF;

endpackage

// File: rtl/fb_write_engine.sv
// Emits `count` consecutive RAM writes starting at `base`, one per cycle,
// wrapping the address at MAX_A.
module fb_write_engine #(
    parameter int ADDR_W = 19,
    parameter int MAX_A  = 307200
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        colour,
    input  logic [ADDR_W:0]   count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              done,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_A - 1);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);

    logic [ADDR_W:0] remain;

    assign next_addr = (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
    // done marks the cycle carrying the final write
    assign done      = wr_en && (remain == ONE_CNT);

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            remain  <= '0;
        end else if (start) begin
            wr_en   <= 1'b1;
            wr_addr <= base;
            wr_data <= colour;
            remain  <= count;
        end else if (wr_en) begin
            wr_addr <= next_addr;
            remain  <= remain - ONE_CNT;
            if (remain == ONE_CNT)
                wr_en <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses sync/command packets from the UART RX stream into framebuffer writes
// and answers each packet with a single ACK/NAK byte.
module uart_frame_loader
    import uart2vga_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int ADDR_W      = 19,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int MAX_A = max_addr(WIDTH, HEIGHT);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    loader_state_t state, nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic              nak;
    logic [TMR_W-1:0]  timer;
    logic [8:0]        len_cnt;
    logic [7:0]        b0, b1;

    logic              byte_ok, byte_bad, in_timed, timeout;
    logic [18:0]       set_addr;
    logic              addr_ok, cmd_known, nak_set;
    logic              eng_start, eng_done;
    logic [ADDR_W-1:0] eng_base, eng_next;
    logic [2:0]        eng_colour;
    logic [ADDR_W:0]   eng_count;

    assign byte_ok   = rx_done && !rx_err;
    assign byte_bad  = rx_done && rx_err;
    assign in_timed  = (state != S_IDLE) && (state != S_EXPAND) &&
                       (state != S_CLEAR) && (state != S_RESP);
    assign timeout   = in_timed && !rx_done && (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign set_addr  = {b0[2:0], b1, rx_data};
    assign addr_ok   = {13'd0, set_addr} < 32'(MAX_A);
    assign cmd_known = (rx_data == CMD_SET_ADDR) || (rx_data == CMD_PIXELS) ||
                       (rx_data == CMD_CLEAR);

    always_ff @(posedge clk_sys) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (in_timed && (byte_bad || timeout)) begin
            nxt = S_RESP;
        end else begin
            case (state)
                S_IDLE:   if (byte_ok && rx_data == SYNC_BYTE) nxt = S_CMD;
                S_CMD:    if (byte_ok) begin
                              case (rx_data)
                                  CMD_SET_ADDR: nxt = S_ADDR0;
                                  CMD_PIXELS:   nxt = S_LEN;
                                  CMD_CLEAR:    nxt = S_CCOL;
                                  default:      nxt = S_RESP;
                              endcase
                          end
                S_ADDR0:  if (byte_ok) nxt = S_ADDR1;
                S_ADDR1:  if (byte_ok) nxt = S_ADDR2;
                S_ADDR2:  if (byte_ok) nxt = S_RESP;
                S_LEN:    if (byte_ok) nxt = S_DATA;
                S_DATA:   if (byte_ok) nxt = S_EXPAND;
                S_EXPAND: if (eng_done) nxt = (len_cnt == 9'd0) ? S_RESP : S_DATA;
                S_CCOL:   if (byte_ok) nxt = S_CLEAR;
                S_CLEAR:  if (eng_done) nxt = S_RESP;
                S_RESP:   if (tx_ready) nxt = S_IDLE;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        tx_valid   = (state == S_RESP);
        tx_data    = (state == S_RESP) ? (nak ? NAK : ACK) : 8'h00;
        eng_start  = 1'b0;
        eng_base   = cur_addr;
        eng_colour = rx_data[2:0];
        eng_count  = (ADDR_W+1)'(rx_data[7:3]) + (ADDR_W+1)'(1);
        nak_set    = 1'b0;
        if (state == S_DATA && byte_ok)
            eng_start = 1'b1;
        if (state == S_CCOL && byte_ok) begin
            eng_start = 1'b1;
            eng_base  = '0;
            eng_count = (ADDR_W+1)'(MAX_A);
        end
        // bytes landing while the write engine is busy are overruns
        if ((in_timed && (byte_bad || timeout)) ||
            (state == S_CMD && byte_ok && !cmd_known) ||
            (state == S_ADDR2 && byte_ok && !addr_ok) ||
            ((state == S_EXPAND || state == S_CLEAR) && rx_done))
            nak_set = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cur_addr <= '0;
            nak      <= 1'b0;
            timer    <= '0;
            len_cnt  <= '0;
            b0       <= '0;
            b1       <= '0;
            err_cnt  <= '0;
        end else begin
            timer <= (!in_timed || rx_done) ? '0 : timer + TMR_W'(1);
            if (state == S_RESP && tx_ready) begin
                nak <= 1'b0;
                if (nak && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end else if (nak_set) begin
                nak <= 1'b1;
            end
            if (state == S_ADDR0 && byte_ok) b0 <= rx_data;
            if (state == S_ADDR1 && byte_ok) b1 <= rx_data;
            if (state == S_ADDR2 && byte_ok && addr_ok) cur_addr <= ADDR_W'(set_addr);
            if (state == S_LEN && byte_ok)
                len_cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            if (state == S_DATA && byte_ok) len_cnt <= len_cnt - 9'd1;
            if (state == S_EXPAND && eng_done) cur_addr <= eng_next;
            if (state == S_CLEAR && eng_done)  cur_addr <= '0;
        end
    end

    fb_write_engine #(
        .ADDR_W (ADDR_W),
        .MAX_A  (MAX_A)
    ) u_engine (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .start     (eng_start),
        .base      (eng_base),
        .colour    (eng_colour),
        .count     (eng_count),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (eng_done),
        .next_addr (eng_next)
    );

endmodule
